// File: rtl/unibus_arbiter.sv
// Two-port sequencer/arbiter for the shared multiplexed uniBus (fetch = port 0, data = port 1).
// Define UNIBUS_ARB_RR_EN for round-robin arbitration; default is fixed priority with port 1 first.
module unibus_arbiter #(
  parameter int unsigned DW        = 8,
  parameter int unsigned DATA_WAIT = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [DW-1:0] addr0,
  input  logic [DW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  input  logic [DW-1:0] bus_in,
  output logic          mem_ale,
  output logic          mem_rd,
  output logic          mem_wr
);

  localparam logic [3:0] LP_WAIT = 4'(DATA_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_TURN,
    S_WDATA,
    S_RDATA,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_port;
  logic          r_we;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_rdata;
  logic          w_req_any;
  logic          w_win;
  logic          w_last;
  logic          w_gnt;
  logic          w_done;

  assign w_req_any = req0 | req1;
  assign w_last    = (r_cnt == '0);

`ifdef UNIBUS_ARB_RR_EN
  logic r_last;

  // On a tie the port that was not served last wins; r_last resets to port 0.
  assign w_win = req1 & (~req0 | ~r_last);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_last <= 1'b0;
    end else if (r_state == S_IDLE && w_req_any) begin
      r_last <= w_win;
    end
  end
`else
  assign w_win = req1;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req_any) begin
        r_port  <= w_win;
        r_we    <= w_win ? we1 : we0;
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
      end
      if (r_state == S_ADDR) begin
        r_cnt <= LP_WAIT;
      end else if ((r_state == S_WDATA || r_state == S_RDATA) && !w_last) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_RDATA && w_last) begin
        r_rdata <= bus_in;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_gnt   = 1'b0;
    w_done  = 1'b0;
    bus_out = '0;
    bus_oe  = 1'b0;
    mem_ale = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_any) w_next = S_ADDR;
      end
      S_ADDR: begin
        w_gnt   = 1'b1;
        bus_out = r_addr;
        bus_oe  = 1'b1;
        mem_ale = 1'b1;
        w_next  = r_we ? S_WDATA : S_TURN;
      end
      S_TURN: begin
        w_gnt  = 1'b1;
        mem_rd = 1'b1;
        w_next = S_RDATA;
      end
      S_WDATA: begin
        w_gnt   = 1'b1;
        bus_out = r_wdata;
        bus_oe  = 1'b1;
        mem_wr  = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_RDATA: begin
        w_gnt  = 1'b1;
        mem_rd = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    gnt0  = w_gnt & ~r_port;
    gnt1  = w_gnt & r_port;
    done0 = w_done & ~r_port;
    done1 = w_done & r_port;
  end

  assign busy  = (r_state != S_IDLE);
  assign rdata = r_rdata;

endmodule

// File: tb/tb_unibus_arbiter.sv
// Directed bench for unibus_arbiter: instance A (DATA_WAIT=0) and instance B (DATA_WAIT=2),
// each with its own memory model on the bus; expected accesses go through a scoreboard queue.
module tb_unibus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;

  logic       gnt0_a, gnt1_a, done0_a, done1_a, busy_a, oe_a, ale_a, rd_a, wr_a;
  logic [7:0] rdata_a, bo_a, bi_a;
  logic       gnt0_b, gnt1_b, done0_b, done1_b, busy_b, oe_b, ale_b, rd_b, wr_b;
  logic [7:0] rdata_b, bo_b, bi_b;

  unibus_arbiter #(.DW(8), .DATA_WAIT(0)) u_dut_a (
    .CLK(clk), .RST(rst_a), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a), .rdata(rdata_a),
    .busy(busy_a), .bus_out(bo_a), .bus_oe(oe_a), .bus_in(bi_a),
    .mem_ale(ale_a), .mem_rd(rd_a), .mem_wr(wr_a)
  );

  unibus_arbiter #(.DW(8), .DATA_WAIT(2)) u_dut_b (
    .CLK(clk), .RST(rst_b), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b), .rdata(rdata_b),
    .busy(busy_b), .bus_out(bo_b), .bus_oe(oe_b), .bus_in(bi_b),
    .mem_ale(ale_b), .mem_rd(rd_b), .mem_wr(wr_b)
  );

  // Memory contents default to addr+0x10 until written.
  function automatic logic [7:0] dflt(input logic [7:0] a);
    return a + 8'h10;
  endfunction

  logic [7:0]   lat_a, lat_b;
  logic [255:0] wv_a, wv_b;
  logic [7:0]   wm_a [256];
  logic [7:0]   wm_b [256];

  always @(posedge clk) begin
    if (!rst_a) begin
      wv_a <= '0;
    end else begin
      if (ale_a) lat_a <= bo_a;
      if (wr_a) begin
        wm_a[lat_a] <= bo_a;
        wv_a[lat_a] <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_b) begin
      wv_b <= '0;
    end else begin
      if (ale_b) lat_b <= bo_b;
      if (wr_b) begin
        wm_b[lat_b] <= bo_b;
        wv_b[lat_b] <= 1'b1;
      end
    end
  end

  assign bi_a = rd_a ? (wv_a[lat_a] ? wm_a[lat_a] : dflt(lat_a)) : 8'hEE;
  assign bi_b = rd_b ? (wv_b[lat_b] ? wm_b[lat_b] : dflt(lat_b)) : 8'hEE;

  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] rd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [256];
  logic [7:0] held_a, held_b;
  int         n_chk = 0;
  int         n_pass = 0;

  // {gnt1,gnt0,done1,done0,busy,bus_oe,mem_ale,mem_rd,mem_wr}
  function automatic logic [8:0] ctl(input bit b);
    if (b) return {gnt1_b, gnt0_b, done1_b, done0_b, busy_b, oe_b, ale_b, rd_b, wr_b};
    return {gnt1_a, gnt0_a, done1_a, done0_a, busy_a, oe_a, ale_a, rd_a, wr_a};
  endfunction

  function automatic logic [7:0] bo(input bit b);
    return b ? bo_b : bo_a;
  endfunction

  function automatic logic [7:0] rdat(input bit b);
    return b ? rdata_b : rdata_a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Called in the IDLE cycle that samples the request; returns in the DONE cycle.
  task automatic serve(input bit b, input bit port, input bit we, input logic [7:0] addr,
                       input logic [7:0] wd, input int unsigned w, input string tag);
    exp_t       e;
    logic [1:0] g;
    g      = port ? 2'b10 : 2'b01;
    e.port = port;
    e.we   = we;
    e.addr = addr;
    e.wd   = wd;
    if (we) begin
      ref_mem[addr] = wd;
      e.rd = b ? held_b : held_a;
    end else begin
      e.rd = ref_mem[addr];
      if (b) held_b = e.rd;
      else held_a = e.rd;
    end
    sb.push_back(e);

    tick();
    chk({tag, ":addr_ctl"}, 32'(ctl(b)), 32'({g, 2'b00, 5'b11100}));
    chk({tag, ":addr_bus"}, 32'(bo(b)), 32'(addr));
    addr0  = 8'($urandom);
    addr1  = 8'($urandom);
    wdata0 = 8'($urandom);
    wdata1 = 8'($urandom);
    we0    = ~we0;
    we1    = ~we1;

    if (we) begin
      for (int unsigned i = 0; i <= w; i++) begin
        tick();
        chk({tag, ":wdata_ctl"}, 32'(ctl(b)), 32'({g, 2'b00, 5'b11001}));
        chk({tag, ":wdata_bus"}, 32'(bo(b)), 32'(wd));
      end
    end else begin
      tick();
      chk({tag, ":turn_ctl"}, 32'(ctl(b)), 32'({g, 2'b00, 5'b10010}));
      for (int unsigned i = 0; i <= w; i++) begin
        tick();
        chk({tag, ":rdata_ctl"}, 32'(ctl(b)), 32'({g, 2'b00, 5'b10010}));
      end
    end

    tick();
    e = sb.pop_front();
    chk({tag, ":done_ctl"}, 32'(ctl(b)), 32'({2'b00, (e.port ? 2'b10 : 2'b01), 5'b10000}));
    chk({tag, ":rdata"}, 32'(rdat(b)), 32'(e.rd));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = dflt(8'(i));
    held_a = 8'h00;
    held_b = 8'h00;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    req0   = 1'b1;
    req1   = 1'b0;
    we0    = 1'b0;
    we1    = 1'b0;
    addr0  = 8'h02;
    addr1  = 8'h00;
    wdata0 = 8'h00;
    wdata1 = 8'h00;

    // Reset held with a pending request: nothing may be granted.
    tick();
    tick();
    chk("reset_ctl_a", 32'(ctl(0)), 32'h0);
    chk("reset_rdata_a", 32'(rdata_a), 32'h0);
    chk("reset_ctl_b", 32'(ctl(1)), 32'h0);
    chk("reset_bus_a", 32'({oe_a, bo_a}), 32'h0);

    // Read port 0 of mem[2] right after reset release.
    rst_a = 1'b1;
    serve(0, 0, 0, 8'h02, 8'h00, 0, "rd0_02");
    req0 = 1'b0;
    tick();
    chk("idle_after_rd", 32'(ctl(0)), 32'h0);

    // Write port 1 to 0xFF, then read it back on port 0.
    req1   = 1'b1;
    we1    = 1'b1;
    addr1  = 8'hFF;
    wdata1 = 8'hAA;
    serve(0, 1, 1, 8'hFF, 8'hAA, 0, "wr1_ff");
    req1 = 1'b0;
    tick();
    req0  = 1'b1;
    we0   = 1'b0;
    addr0 = 8'hFF;
    serve(0, 0, 0, 8'hFF, 8'h00, 0, "rd0_ff");
    req0 = 1'b0;
    tick();

    // Both ports requesting continuously for four accesses.
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit exp_port;
`ifdef UNIBUS_ARB_RR_EN
      exp_port = (i % 2 == 0);
`else
      exp_port = 1'b1;
`endif
      we0   = 1'b0;
      we1   = 1'b0;
      addr0 = 8'h02;
      addr1 = 8'h03;
      serve(0, exp_port, 0, exp_port ? 8'h03 : 8'h02, 8'h00, 0, "arb");
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      we0   = 1'b0;
      we1   = 1'b0;
      addr0 = 8'h02;
      addr1 = 8'h03;
      tick();
      chk("arb_bubble", 32'(ctl(0)), 32'h0);
    end

    // Reset asserted in the middle of a write data phase.
    req1   = 1'b1;
    we1    = 1'b1;
    addr1  = 8'h40;
    wdata1 = 8'h77;
    tick();
    chk("rstwr_addr_ctl", 32'(ctl(0)), 32'({2'b10, 2'b00, 5'b11100}));
    tick();
    chk("rstwr_wdata_ctl", 32'(ctl(0)), 32'({2'b10, 2'b00, 5'b11001}));
    rst_a = 1'b0;
    req1  = 1'b0;
    tick();
    held_a = 8'h00;
    chk("rstwr_ctl", 32'(ctl(0)), 32'h0);
    chk("rstwr_rdata", 32'(rdata_a), 32'(held_a));
    rst_a = 1'b1;
    tick();
    chk("rstwr_nodone1", 32'(ctl(0)), 32'h0);
    tick();
    chk("rstwr_nodone2", 32'(ctl(0)), 32'h0);

    // DATA_WAIT=2 read on instance B; A is parked in reset.
    rst_a = 1'b0;
    rst_b = 1'b1;
    req0  = 1'b1;
    we0   = 1'b0;
    addr0 = 8'h03;
    serve(1, 0, 0, 8'h03, 8'h00, 2, "rdw2_03");
    req0 = 1'b0;
    tick();
    chk("rdw2_idle", 32'(ctl(1)), 32'h0);
    chk("rdw2_hold", 32'(rdata_b), 32'h13);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
